// File: rtl/rr_mux_pkg.sv
// Shared definitions for the N:1 channel selector: mode encodings and packed-bus helpers.
package rr_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // LSB offset of channel 'index' within a packed bus of 'width'-bit channels.
    function automatic int unsigned ch_slice(input int unsigned index, input int unsigned width);
        return index * width;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority picker: lowest requesting index at or above ptr, else lowest overall.
module rr_priority_pick #(
    parameter  int unsigned NUM_CH = 4,
    localparam int unsigned SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  gnt,
    output logic              gnt_valid
);

    logic [SEL_W-1:0] any_gnt;
    logic [SEL_W-1:0] hi_gnt;
    logic             hi_valid;

    // Descending scans leave the lowest qualifying index in each candidate.
    always_comb begin
        any_gnt  = '0;
        hi_gnt   = '0;
        hi_valid = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                any_gnt = SEL_W'(i);
                if (SEL_W'(i) >= ptr) begin
                    hi_gnt   = SEL_W'(i);
                    hi_valid = 1'b1;
                end
            end
        end
    end

    assign gnt_valid = |req;
    assign gnt       = hi_valid ? hi_gnt : any_gnt;

endmodule

// File: rtl/rr_mux_nto1.sv
// N:1 selector with fixed or round-robin grant feeding a one-entry valid/ready output register.
module rr_mux_nto1
    import rr_mux_pkg::*;
#(
    parameter  int unsigned WIDTH  = 4,
    parameter  int unsigned NUM_CH = 4,
    localparam int unsigned SEL_W  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic [SEL_W-1:0] rr_gnt;
    logic             rr_valid;
    logic             fix_valid;
    logic [SEL_W-1:0] gnt;
    logic             gnt_valid;
    logic             load;
    logic             xfer;
    logic [WIDTH-1:0] gnt_data;

    rr_priority_pick #(
        .NUM_CH (NUM_CH)
    ) u_pick (
        .req       (in_valid),
        .ptr       (ptr_q),
        .gnt       (rr_gnt),
        .gnt_valid (rr_valid)
    );

    // Fixed-mode lookup; a select beyond the last channel matches nothing.
    always_comb begin
        fix_valid = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel == SEL_W'(i)) fix_valid = in_valid[i];
        end
    end

    assign gnt       = (mode == MODE_RR) ? rr_gnt : sel;
    assign gnt_valid = (mode == MODE_RR) ? rr_valid : fix_valid;
    assign load      = ~out_valid_q | out_ready;
    assign xfer      = rst_n & load & gnt_valid;

    always_comb begin
        in_ready = '0;
        gnt_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt == SEL_W'(i)) begin
                in_ready[i] = xfer;
                gnt_data    = in_data[ch_slice(i, WIDTH) +: WIDTH];
            end
        end
    end

    // Output register and round-robin pointer update.
    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_data_d  = gnt_data;
            out_ch_d    = gnt;
            out_valid_d = 1'b1;
            if (mode == MODE_RR) begin
                ptr_d = (gnt == SEL_W'(NUM_CH - 1)) ? '0 : gnt + SEL_W'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux_nto1.sv
// Directed bench for rr_mux_nto1: a 4-channel instance and a 3-channel instance for the select boundary.
module tb_rr_mux_nto1;

    logic clk = 1'b0;
    logic rst_n;

    logic [15:0] in_data4;
    logic [3:0]  in_valid4, in_ready4;
    logic        mode4;
    logic [1:0]  sel4;
    logic [3:0]  out_data4;
    logic [1:0]  out_ch4;
    logic        out_valid4, out_ready4;

    logic [11:0] in_data3;
    logic [2:0]  in_valid3, in_ready3;
    logic        mode3;
    logic [1:0]  sel3;
    logic [3:0]  out_data3;
    logic [1:0]  out_ch3;
    logic        out_valid3, out_ready3;

    int n_checks = 0;
    int n_errors = 0;
    logic [3:0] ch_val [4];

    always #5 clk = ~clk;

    rr_mux_nto1 #(.WIDTH(4), .NUM_CH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data4), .in_valid(in_valid4),
        .in_ready(in_ready4), .mode(mode4), .sel(sel4), .out_data(out_data4),
        .out_ch(out_ch4), .out_valid(out_valid4), .out_ready(out_ready4)
    );

    rr_mux_nto1 #(.WIDTH(4), .NUM_CH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .mode(mode3), .sel(sel3), .out_data(out_data3),
        .out_ch(out_ch3), .out_valid(out_valid3), .out_ready(out_ready3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] rr_seq [3];
        ch_val[0] = 4'd1; ch_val[1] = 4'd2; ch_val[2] = 4'd2; ch_val[3] = 4'd3;
        rr_seq[0] = 4'b0010; rr_seq[1] = 4'b1000; rr_seq[2] = 4'b0010;

        rst_n = 1'b0;
        in_data4 = 16'h3221; in_valid4 = 4'b1111; mode4 = 1'b0; sel4 = 2'd0; out_ready4 = 1'b1;
        in_data3 = 12'h321;  in_valid3 = 3'b000;  mode3 = 1'b0; sel3 = 2'd0; out_ready3 = 1'b1;
        #2;
        check("rst_out_valid", 32'(out_valid4), 32'd0);
        check("rst_out_data", 32'(out_data4), 32'd0);
        check("rst_out_ch", 32'(out_ch4), 32'd0);
        check("rst_in_ready", 32'(in_ready4), 32'd0);
        #10;
        rst_n = 1'b1;

        // Fixed-mode select sweep.
        for (int k = 0; k < 4; k++) begin
            sel4 = 2'(k);
            #1;
            check("fix_in_ready", 32'(in_ready4), 32'(4'b0001 << k));
            tick();
            check("fix_out_data", 32'(out_data4), 32'(ch_val[k]));
            check("fix_out_ch", 32'(out_ch4), 32'(k));
            check("fix_out_valid", 32'(out_valid4), 32'd1);
        end

        // Round-robin with every channel requesting.
        mode4 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("rr_all_in_ready", 32'(in_ready4), 32'(4'b0001 << (k % 4)));
            tick();
            check("rr_all_out_ch", 32'(out_ch4), 32'(k % 4));
            check("rr_all_out_data", 32'(out_data4), 32'(ch_val[k % 4]));
        end

        // Round-robin with sparse requests.
        pulse_reset();
        in_valid4 = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("rr_sparse_in_ready", 32'(in_ready4), 32'(rr_seq[k]));
            tick();
            check("rr_sparse_out_ch", 32'(out_ch4), (k == 1) ? 32'd3 : 32'd1);
        end

        // Backpressure: drain, load word 5, hold, then drain-and-reload in one cycle.
        mode4 = 1'b0; in_valid4 = 4'b0000; in_data4 = 16'h3295; sel4 = 2'd0;
        tick();
        check("bp_drained", 32'(out_valid4), 32'd0);
        in_valid4 = 4'b0001; out_ready4 = 1'b0;
        tick();
        check("bp_loaded", 32'(out_data4), 32'd5);
        in_valid4 = 4'b0010; sel4 = 2'd1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_in_ready", 32'(in_ready4), 32'd0);
            tick();
            check("bp_hold_data", 32'(out_data4), 32'd5);
            check("bp_hold_valid", 32'(out_valid4), 32'd1);
            check("bp_hold_ch", 32'(out_ch4), 32'd0);
        end
        out_ready4 = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready4), 32'b0010);
        tick();
        check("bp_next_data", 32'(out_data4), 32'd9);
        check("bp_next_ch", 32'(out_ch4), 32'd1);
        check("bp_next_valid", 32'(out_valid4), 32'd1);
        in_valid4 = 4'b0000;
        tick();
        check("drain_valid", 32'(out_valid4), 32'd0);
        check("drain_data_hold", 32'(out_data4), 32'd9);

        // Asynchronous reset while holding a word with ptr at 2.
        mode4 = 1'b1; in_valid4 = 4'b0010;
        tick();
        check("pre_rst_ch", 32'(out_ch4), 32'd1);
        out_ready4 = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid4), 32'd0);
        check("async_rst_data", 32'(out_data4), 32'd0);
        check("async_rst_ch", 32'(out_ch4), 32'd0);
        check("async_rst_in_ready", 32'(in_ready4), 32'd0);
        tick();
        rst_n = 1'b1;
        in_valid4 = 4'b1111; out_ready4 = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready4), 32'b0001);
        tick();
        check("post_rst_out_ch", 32'(out_ch4), 32'd0);

        // Three-channel instance: select beyond the last channel grants nothing.
        in_valid3 = 3'b111; sel3 = 2'd3;
        #1;
        check("n3_sel3_in_ready", 32'(in_ready3), 32'd0);
        tick();
        check("n3_sel3_valid", 32'(out_valid3), 32'd0);
        check("n3_sel3_data", 32'(out_data3), 32'd0);
        check("n3_sel3_ch", 32'(out_ch3), 32'd0);
        sel3 = 2'd2;
        #1;
        check("n3_sel2_in_ready", 32'(in_ready3), 32'b100);
        tick();
        check("n3_sel2_data", 32'(out_data3), 32'd3);
        check("n3_sel2_ch", 32'(out_ch3), 32'd2);
        mode3 = 1'b1; in_valid3 = 3'b101;
        #1;
        check("n3_rr_wrap_ready", 32'(in_ready3), 32'b001);
        tick();
        check("n3_rr_wrap_ch", 32'(out_ch3), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
